// File: rtl/seg_dynamic_mux.sv
// Multiplexed common-anode 7-segment driver with a sequential
// double-dabble BCD converter, blanking, points, sign and overflow.
module seg_dynamic_mux #(
  parameter int          DIGITS  = 6,
  parameter int          DATA_W  = 20,
  parameter logic [24:0] CNT_MAX = 25'd49_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [DIGITS-1:0] point,
  input  logic              sign,
  input  logic              seg_en,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg,
  output logic              busy
);

  localparam int BN0 = (DATA_W * 3) / 10 + 1;
  localparam int BN  = BN0 > DIGITS ? BN0 : DIGITS;
  localparam int BW  = 4 * BN;
  localparam int IW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int SW  = $clog2(DATA_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic              first;
  logic [DATA_W-1:0] last;
  logic [DATA_W-1:0] bin;
  logic [BW-1:0]     work;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     disp;
  logic [SW-1:0]     step;

  function automatic logic [7:0] dec(input logic [3:0] n);
    unique case (n)
      4'd0:    dec = 8'hC0;
      4'd1:    dec = 8'hF9;
      4'd2:    dec = 8'hA4;
      4'd3:    dec = 8'hB0;
      4'd4:    dec = 8'h99;
      4'd5:    dec = 8'h92;
      4'd6:    dec = 8'h82;
      4'd7:    dec = 8'hF8;
      4'd8:    dec = 8'h80;
      4'd9:    dec = 8'h90;
      default: dec = 8'hFF;
    endcase
  endfunction

  always_comb begin
    adj = work;
    for (int i = 0; i < BN; i++) begin
      if (work[4*i+:4] >= 4'd5)
        adj[4*i+:4] = work[4*i+:4] + 4'd3;
    end
  end

  // disp only changes in DONE, so a partial result is never shown
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      first <= 1'b1;
      last  <= '0;
      bin   <= '0;
      work  <= '0;
      disp  <= '0;
      step  <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (first || data != last) begin
            first <= 1'b0;
            last  <= data;
            bin   <= data;
            work  <= '0;
            step  <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= BW'({adj, bin[DATA_W-1]});
          bin  <= bin << 1;
          step <= step + 1'b1;
          if (step == SW'(DATA_W - 1))
            state <= DONE;
        end
        DONE: begin
          disp  <= work;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [IW-1:0] top;
  logic [IW-1:0] hpos;
  logic          vovf;
  logic          ovf;
  logic [7:0]    glyph [DIGITS];

  always_comb begin
    top = '0;
    for (int i = 1; i < DIGITS; i++)
      if (disp[4*i+:4] != 4'd0) top = IW'(i);
    hpos = top;
    for (int i = 0; i < DIGITS; i++)
      if (point[i] && IW'(i) > hpos) hpos = IW'(i);
    vovf = 1'b0;
    for (int i = DIGITS; i < BN; i++)
      if (disp[4*i+:4] != 4'd0) vovf = 1'b1;
    // a sign needs one free position above the highest shown digit
    ovf = vovf | (sign & (hpos == IW'(DIGITS - 1)));
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      glyph[i] = 8'hFF;
      if (ovf)
        glyph[i] = 8'hBF;
      else if (IW'(i) <= top || point[i])
        glyph[i] = dec(disp[4*i+:4]) & {~point[i], 7'h7F};
      else if (sign && ({1'b0, hpos} + 1'b1) == (IW + 1)'(i))
        glyph[i] = 8'hBF;
    end
  end

  logic [24:0]   cnt;
  logic [IW-1:0] idx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
      idx <= '0;
      sel <= '0;
      seg <= 8'hFF;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (seg_en) begin
        sel <= DIGITS'(1) << idx;
        seg <= glyph[idx];
      end else begin
        sel <= '0;
        seg <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_dynamic_mux.sv
// Scoreboard bench for seg_dynamic_mux: stimulus queues expected
// digit presentations, a monitor pops one per sel change.
module tb_seg_dynamic_mux;

  localparam int DIGITS = 6;
  localparam int DATA_W = 20;
  localparam int PER    = 25;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic [DIGITS-1:0] point = '0;
  logic              sign = 1'b0;
  logic              seg_en = 1'b1;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;
  logic              busy;

  seg_dynamic_mux #(
    .DIGITS (DIGITS),
    .DATA_W (DATA_W),
    .CNT_MAX(25'd24)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .data     (data),
    .point    (point),
    .sign     (sign),
    .seg_en   (seg_en),
    .sel      (sel),
    .seg      (seg),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc;
  logic [13:0] exp_q[$];
  logic [13:0] mon_e;
  logic [5:0]  prev_sel = '0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] glyph_of(int n);
    logic [7:0] t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return t[n];
  endfunction

  // decimal digits via division, then blanking/sign/overflow rules
  function automatic logic [7:0] model_seg(int unsigned v, logic [5:0] pt,
                                           logic sg, int d);
    int          dig[6];
    int unsigned p = 1;
    int          top = 0;
    int          h;
    logic [7:0]  g;
    for (int i = 0; i < 6; i++) begin
      dig[i] = int'((v / p) % 10);
      p = p * 10;
    end
    for (int i = 1; i < 6; i++) if (dig[i] != 0) top = i;
    h = top;
    for (int i = 0; i < 6; i++) if (pt[i] && i > h) h = i;
    if (v > 999999 || (sg && h == 5)) return 8'hBF;
    if (d <= top || pt[d]) begin
      g = glyph_of(dig[d]);
      if (pt[d]) g[7] = 1'b0;
    end else if (sg && d == h + 1) begin
      g = 8'hBF;
    end else begin
      g = 8'hFF;
    end
    return g;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sel = '0;
    end else begin
      if (sel !== prev_sel && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("scan sel/seg", {18'd0, sel, seg}, {18'd0, mon_e});
      end
      prev_sel = sel;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scan timeout: pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic scan_check();
    int unsigned c = cyc;
    int          m = (c == 0) ? 0 : int'((c - 1) / PER) + 1;
    int          d;
    for (int k = 0; k < DIGITS; k++) begin
      d = (m + k) % DIGITS;
      exp_q.push_back({6'(1 << d), model_seg(data, point, sign, d)});
    end
    wait_drain(8 * PER);
  endtask

  task automatic show(int unsigned v, logic [5:0] pt, logic sg);
    data = DATA_W'(v);
    point = pt;
    sign = sg;
    tick(30);
    scan_check();
  endtask

  int          bcnt;
  int unsigned rv;
  int          d;

  initial begin
    #12;
    check("reset sel", 32'(sel), 32'h0);
    check("reset seg", 32'(seg), 32'hFF);
    check("reset busy", 32'(busy), 32'h0);
    #8 rst_n = 1'b1;
    #1;
    scan_check();

    data = 20'd123456;
    bcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    #1;
    check("busy length", 32'(bcnt), 32'd21);
    scan_check();

    show(42, 6'b000010, 1'b1);
    show(1000000, 6'b101010, 1'b0);
    show(123456, 6'b000001, 1'b1);
    show(999999, 6'b000000, 1'b0);
    show(12345, 6'b000000, 1'b1);
    show(5, 6'b000010, 1'b0);
    show(0, 6'b100000, 1'b0);
    show(0, 6'b000000, 1'b1);

    for (int it = 0; it < 6; it++) begin
      rv = $urandom % (10 ** $urandom_range(1, 7));
      if (rv > 1048575) rv = rv % 1048576;
      show(rv, 6'($urandom), 1'($urandom));
    end

    tick(7);
    seg_en = 1'b0;
    exp_q.push_back({6'b0, 8'hFF});
    @(posedge clk);
    #1;
    check("disable sel", 32'(sel), 32'h0);
    check("disable seg", 32'(seg), 32'hFF);
    tick(1);
    wait_drain(3);
    tick(40 + int'($urandom_range(0, 60)));
    seg_en = 1'b1;
    d = int'((cyc / PER) % DIGITS);
    exp_q.push_back({6'(1 << d), model_seg(data, point, sign, d)});
    wait_drain(5);
    scan_check();

    data = 20'd111111;
    tick(4);
    data = 20'd222222;
    tick(4);
    data = 20'd654321;
    tick(60);
    scan_check();

    point = '0;
    sign = 1'b0;
    tick(30);
    data = 20'd777;
    tick(5);
    rst_n = 1'b0;
    #1;
    check("pulse sel", 32'(sel), 32'h0);
    check("pulse seg", 32'(seg), 32'hFF);
    check("pulse busy", 32'(busy), 32'h0);
    #1 rst_n = 1'b1;
    exp_q.push_back({6'b000001, model_seg(0, point, sign, 0)});
    wait_drain(5);
    tick(30);
    scan_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
